// File: rtl/fpu_unit_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the shared FPU sub-unit.
// The slave modport is the arbiter's view; master is the environment's view.
interface fpu_unit_arbiter_if #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 45,
    parameter int RESULT_W  = 34
);
    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_ready;
    logic [NUM_REQ-1:0][PAYLOAD_W-1:0] req_payload;
    logic [NUM_REQ-1:0]                req_flush;
    logic [NUM_REQ-1:0]                rsp_valid;
    logic [NUM_REQ-1:0]                rsp_ready;
    logic [RESULT_W-1:0]               rsp_payload;
    logic                              unit_valid_in;
    logic                              unit_ready_out;
    logic [PAYLOAD_W-1:0]              unit_payload;
    logic                              unit_valid_out;
    logic                              unit_ready_in;
    logic [RESULT_W-1:0]               unit_result;

    modport slave (
        input  req_valid, req_payload, req_flush, rsp_ready,
               unit_ready_out, unit_valid_out, unit_result,
        output req_ready, rsp_valid, rsp_payload,
               unit_valid_in, unit_payload, unit_ready_in
    );

    modport master (
        output req_valid, req_payload, req_flush, rsp_ready,
               unit_ready_out, unit_valid_out, unit_result,
        input  req_ready, rsp_valid, rsp_payload,
               unit_valid_in, unit_payload, unit_ready_in
    );
endinterface

// File: rtl/fpu_unit_arbiter.sv
// Round-robin sharing of one pipelined FPU sub-unit between NUM_REQ requesters.
// An in-order owner FIFO routes each unit result back to the requester that issued it.
module fpu_unit_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int PAYLOAD_W = 45,
    parameter int RESULT_W  = 34,
    parameter int MAX_OUT   = 2   // power of 2, at least 2
) (
    input  logic              clk,
    input  logic              reset_n,
    fpu_unit_arbiter_if.slave bus
);
    localparam int OW = $clog2(NUM_REQ);
    localparam int PW = $clog2(MAX_OUT);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [OW-1:0] owner;
        logic          drop;
    } entry_t;

    entry_t [MAX_OUT-1:0] fifo_q, fifo_d;
    logic [OW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic [OW-1:0]      grant_idx;
    logic               gnt_any;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [RESULT_W-1:0] rsp_payload;
    logic               unit_ready_in;
    logic               fifo_empty;
    logic               push, pop;
    entry_t             head;

    assign eligible   = bus.req_valid & ~bus.req_flush;
    assign fifo_empty = (cnt_q == '0);
    assign head       = fifo_q[rd_ptr_q];

    // Capacity uses the registered count only, keeping rsp_ready off the req_ready path.
    always_comb begin : p_grant
        int            idx;
        logic [OW-1:0] cand;
        idx       = 0;
        cand      = '0;
        grant     = '0;
        grant_idx = '0;
        gnt_any   = 1'b0;
        if (reset_n && (cnt_q < CW'(MAX_OUT)) && bus.unit_ready_out) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                cand = OW'(idx);
                if (!gnt_any && eligible[cand]) begin
                    gnt_any   = 1'b1;
                    grant_idx = cand;
                end
            end
        end
        if (gnt_any) grant[grant_idx] = 1'b1;
    end

    always_comb begin : p_route
        rsp_valid     = '0;
        rsp_payload   = '0;
        unit_ready_in = 1'b0;
        if (reset_n && bus.unit_valid_out) begin
            // Empty FIFO, dropped head or a flush on the owner: swallow the result.
            if (fifo_empty || head.drop || bus.req_flush[head.owner]) begin
                unit_ready_in = 1'b1;
            end else begin
                rsp_valid[head.owner] = 1'b1;
                rsp_payload           = bus.unit_result;
                unit_ready_in         = bus.rsp_ready[head.owner];
            end
        end
    end

    assign push = gnt_any;
    assign pop  = bus.unit_valid_out && unit_ready_in && !fifo_empty;

    always_comb begin : p_next
        logic [PW-1:0] off;
        off      = '0;
        fifo_d   = fifo_q;
        rr_ptr_d = rr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int e = 0; e < MAX_OUT; e++) begin
            off = PW'(e) - rd_ptr_q;
            if ((CW'(off) < cnt_q) && bus.req_flush[fifo_q[e].owner]) fifo_d[e].drop = 1'b1;
        end
        if (push) begin
            fifo_d[wr_ptr_q] = '{owner: grant_idx, drop: 1'b0};
            wr_ptr_d         = wr_ptr_q + PW'(1);
            rr_ptr_d         = (grant_idx == OW'(NUM_REQ - 1)) ? '0 : grant_idx + OW'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_q   <= '0;
            rr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            fifo_q   <= fifo_d;
            rr_ptr_q <= rr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.req_ready     = grant;
    assign bus.unit_valid_in = gnt_any;
    assign bus.unit_payload  = gnt_any ? bus.req_payload[grant_idx] : '0;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_payload   = rsp_payload;
    assign bus.unit_ready_in = unit_ready_in;
endmodule

// File: tb/tb_fpu_unit_arbiter.sv
// Directed bench for fpu_unit_arbiter; the bench plays both requesters and the shared unit.
module tb_fpu_unit_arbiter;
    localparam int NUM_REQ = 2, PAYLOAD_W = 45, RESULT_W = 34, MAX_OUT = 2;

    // 1.0 and 2.0 as unpacked float bundles; the unit converts them to int 1 and 2.
    localparam logic [PAYLOAD_W-1:0] P0 = {5'd3, 3'd0, 24'h800000, 8'd127, 5'b00000};
    localparam logic [PAYLOAD_W-1:0] P1 = {5'd3, 3'd0, 24'h800000, 8'd128, 5'b00000};
    localparam logic [RESULT_W-1:0]  R0 = {32'd1, 2'b00};
    localparam logic [RESULT_W-1:0]  R1 = {32'd2, 2'b00};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   outstanding;

    fpu_unit_arbiter_if #(.NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .RESULT_W(RESULT_W)) bus ();

    fpu_unit_arbiter #(
        .NUM_REQ(NUM_REQ), .PAYLOAD_W(PAYLOAD_W), .RESULT_W(RESULT_W), .MAX_OUT(MAX_OUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) outstanding <= 0;
        else outstanding <= outstanding + int'(bus.unit_valid_in && bus.unit_ready_out)
                                        - int'(bus.unit_valid_out && bus.unit_ready_in);
    end

    always @(posedge clk) begin
        if (reset_n && bus.unit_valid_out)
            assert (outstanding > 0) else $error("unit result presented with no op outstanding");
    end

    task automatic idle();
        bus.req_valid      = '0;
        bus.req_flush      = '0;
        bus.rsp_ready      = '0;
        bus.unit_ready_out = 1'b0;
        bus.unit_valid_out = 1'b0;
        bus.unit_result    = '0;
        bus.req_payload[0] = P0;
        bus.req_payload[1] = P1;
    endtask

    task automatic test_reset();
        idle();
        bus.req_valid = 2'b11; bus.unit_ready_out = 1'b1; bus.unit_valid_out = 1'b1;
        #1;
        tests_run += 4;
        if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready: got %b want 00", bus.req_ready); end
        if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rsp_valid: got %b want 00", bus.rsp_valid); end
        if (bus.unit_valid_in !== 1'b0) begin tests_failed++; $display("FAIL reset_unit_valid_in: got %b want 0", bus.unit_valid_in); end
        if (bus.unit_ready_in !== 1'b0) begin tests_failed++; $display("FAIL reset_unit_ready_in: got %b want 0", bus.unit_ready_in); end
        idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_alternate();
        logic [1:0] eg;
        logic [RESULT_W-1:0] er;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            idle();
            bus.req_valid = 2'b11; bus.unit_ready_out = 1'b1; bus.rsp_ready = 2'b11;
            er = (i % 2 == 1) ? R0 : R1;
            if (i > 0) begin bus.unit_valid_out = 1'b1; bus.unit_result = er; end
            #1;
            eg = (i % 2 == 0) ? 2'b01 : 2'b10;
            tests_run += 2;
            if (bus.req_ready !== eg) begin tests_failed++; $display("FAIL alt_grant[%0d]: got %b want %b", i, bus.req_ready, eg); end
            if (bus.unit_payload !== ((i % 2 == 0) ? P0 : P1)) begin tests_failed++; $display("FAIL alt_payload[%0d]: got %h", i, bus.unit_payload); end
            if (i > 0) begin
                tests_run += 3;
                if (bus.rsp_valid !== ~eg) begin tests_failed++; $display("FAIL alt_rsp_valid[%0d]: got %b want %b", i, bus.rsp_valid, ~eg); end
                if (bus.rsp_payload !== er) begin tests_failed++; $display("FAIL alt_rsp_payload[%0d]: got %h want %h", i, bus.rsp_payload, er); end
                if (bus.unit_ready_in !== 1'b1) begin tests_failed++; $display("FAIL alt_unit_ready_in[%0d]: got %b want 1", i, bus.unit_ready_in); end
            end
        end
        @(negedge clk);
        idle();
        bus.rsp_ready = 2'b11; bus.unit_valid_out = 1'b1; bus.unit_result = R1;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL alt_drain: got %b want 10", bus.rsp_valid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_max_out();
        idle();
        bus.req_valid = 2'b11; bus.unit_ready_out = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL mo_issue0: got %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.unit_valid_out = 1'b1; bus.unit_result = R0;
        #1;
        tests_run += 3;
        if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL mo_issue1: got %b want 10", bus.req_ready); end
        if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL mo_rsp_valid: got %b want 01", bus.rsp_valid); end
        if (bus.unit_ready_in !== 1'b0) begin tests_failed++; $display("FAIL mo_stall: got %b want 0", bus.unit_ready_in); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests_run += 2;
            if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL mo_full[%0d]: got %b want 00", i, bus.req_ready); end
            if (bus.unit_valid_in !== 1'b0) begin tests_failed++; $display("FAIL mo_full_valid[%0d]: got %b want 0", i, bus.unit_valid_in); end
        end
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        #1;
        tests_run += 3;
        if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL mo_no_bypass: got %b want 00", bus.req_ready); end
        if (bus.unit_ready_in !== 1'b1) begin tests_failed++; $display("FAIL mo_release: got %b want 1", bus.unit_ready_in); end
        if (bus.rsp_payload !== R0) begin tests_failed++; $display("FAIL mo_payload0: got %h want %h", bus.rsp_payload, R0); end
        @(negedge clk);
        bus.unit_result = R1;
        #1;
        tests_run += 2;
        if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL mo_rsp1: got %b want 10", bus.rsp_valid); end
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL mo_reissue: got %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00; bus.unit_result = R0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL mo_drain: got %b want 01", bus.rsp_valid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush_inflight();
        bus.req_valid = 2'b01; bus.unit_ready_out = 1'b1; bus.rsp_ready = 2'b11;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL fl_issue0: got %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b10; bus.req_flush = 2'b01;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL fl_issue1: got %b want 10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00; bus.req_flush = 2'b00;
        bus.unit_valid_out = 1'b1; bus.unit_result = R0;
        #1;
        tests_run += 2;
        if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL fl_discard_valid: got %b want 00", bus.rsp_valid); end
        if (bus.unit_ready_in !== 1'b1) begin tests_failed++; $display("FAIL fl_discard_ready: got %b want 1", bus.unit_ready_in); end
        @(negedge clk);
        bus.unit_result = R1;
        #1;
        tests_run += 2;
        if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL fl_keep_valid: got %b want 10", bus.rsp_valid); end
        if (bus.rsp_payload !== R1) begin tests_failed++; $display("FAIL fl_keep_payload: got %h want %h", bus.rsp_payload, R1); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush_same_cycle();
        bus.req_valid = 2'b10; bus.req_flush = 2'b10; bus.unit_ready_out = 1'b1; bus.rsp_ready = 2'b11;
        #1;
        tests_run += 3;
        if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL fs_no_grant: got %b want 00", bus.req_ready); end
        if (bus.unit_valid_in !== 1'b0) begin tests_failed++; $display("FAIL fs_unit_valid: got %b want 0", bus.unit_valid_in); end
        if (bus.unit_payload !== '0) begin tests_failed++; $display("FAIL fs_payload: got %h want 0", bus.unit_payload); end
        @(negedge clk);
        bus.req_valid = 2'b11; bus.req_flush = 2'b00;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL fs_rr_kept: got %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00; bus.unit_valid_out = 1'b1; bus.unit_result = R0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL fs_drain: got %b want 01", bus.rsp_valid); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_head_stall();
        bus.req_valid = 2'b10; bus.unit_ready_out = 1'b1;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL hs_issue: got %b want 10", bus.req_ready); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.req_valid = 2'b00; bus.rsp_ready = 2'b01;
            bus.unit_valid_out = 1'b1; bus.unit_result = R1;
            #1;
            tests_run += 2;
            if (bus.unit_ready_in !== 1'b0) begin tests_failed++; $display("FAIL hs_stall[%0d]: got %b want 0", i, bus.unit_ready_in); end
            if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL hs_valid[%0d]: got %b want 10", i, bus.rsp_valid); end
        end
        @(negedge clk);
        bus.rsp_ready = 2'b11;
        #1;
        tests_run += 2;
        if (bus.unit_ready_in !== 1'b1) begin tests_failed++; $display("FAIL hs_release: got %b want 1", bus.unit_ready_in); end
        if (bus.rsp_payload !== R1) begin tests_failed++; $display("FAIL hs_payload: got %h want %h", bus.rsp_payload, R1); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_midstream();
        bus.req_valid = 2'b10; bus.unit_ready_out = 1'b1; bus.rsp_ready = 2'b11;
        @(negedge clk);
        bus.req_valid = 2'b11;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL rm_issue: got %b want 01", bus.req_ready); end
        @(negedge clk);
        bus.unit_valid_out = 1'b1; bus.unit_result = R1;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL rm_pre: got %b want 10", bus.rsp_valid); end
        #2 reset_n = 1'b0;
        #1;
        tests_run += 4;
        if (bus.req_ready !== 2'b00) begin tests_failed++; $display("FAIL rm_req_ready: got %b want 00", bus.req_ready); end
        if (bus.rsp_valid !== 2'b00) begin tests_failed++; $display("FAIL rm_rsp_valid: got %b want 00", bus.rsp_valid); end
        if (bus.unit_valid_in !== 1'b0) begin tests_failed++; $display("FAIL rm_unit_valid_in: got %b want 0", bus.unit_valid_in); end
        if (bus.unit_ready_in !== 1'b0) begin tests_failed++; $display("FAIL rm_unit_ready_in: got %b want 0", bus.unit_ready_in); end
        bus.unit_valid_out = 1'b0;
        @(negedge clk);
        idle();
        reset_n = 1'b1;
        @(negedge clk);
        bus.req_valid = 2'b11; bus.unit_ready_out = 1'b1; bus.rsp_ready = 2'b11;
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b01) begin tests_failed++; $display("FAIL rm_first_grant: got %b want 01", bus.req_ready); end
        @(negedge clk);
        #1;
        tests_run++;
        if (bus.req_ready !== 2'b10) begin tests_failed++; $display("FAIL rm_fifo_empty: got %b want 10", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 2'b00; bus.unit_valid_out = 1'b1; bus.unit_result = R0;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b01) begin tests_failed++; $display("FAIL rm_drain0: got %b want 01", bus.rsp_valid); end
        @(negedge clk);
        bus.unit_result = R1;
        #1;
        tests_run++;
        if (bus.rsp_valid !== 2'b10) begin tests_failed++; $display("FAIL rm_drain1: got %b want 10", bus.rsp_valid); end
        @(negedge clk);
        idle();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_max_out();
        test_flush_inflight();
        test_flush_same_cycle();
        test_head_stall();
        test_reset_midstream();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/fpu_unit_arbiter.md
Name: fpu_unit_arbiter

Overview:
Shares one pipelined FPU sub-unit (e.g. the float-to-int converter) between NUM_REQ requesters using round-robin arbitration. Tracks which requester owns each in-flight operation in an in-order owner FIFO. Routes each result back to its owner. Supports per-requester flush, which discards that requester's in-flight results without disturbing the other requesters or the shared unit.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
PAYLOAD_W, 45, request bundle width: op(5), rm(3), man(24), exp(8), sgn, zero, inf, sNaN, qNaN
RESULT_W, 34, result bundle width: int(32), IV, IE
MAX_OUT, 2, maximum operations in flight inside the unit (owner FIFO depth, power of 2)

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester request accepted (grant)
req_payload  in  NUM_REQ*PAYLOAD_W  per-requester operand bundle, requester k at slice k
req_flush  in  NUM_REQ  per-requester flush pulse
rsp_valid  out  NUM_REQ  per-requester result valid
rsp_ready  in  NUM_REQ  per-requester result ready
rsp_payload  out  RESULT_W  unit result, broadcast to all requesters, qualified by rsp_valid
unit_valid_in  out  1  request to shared unit
unit_ready_out  in  1  shared unit can accept
unit_payload  out  PAYLOAD_W  granted requester's bundle
unit_valid_out  in  1  shared unit result valid
unit_ready_in  out  1  result consumed
unit_result  in  RESULT_W  shared unit result bundle

Behaviour:
- Reset (reset_n=0, async): rr_ptr=0, owner FIFO empty (count=0, rd/wr ptr=0), all drop bits 0. All outputs 0: req_ready, rsp_valid, unit_valid_in, unit_ready_in.
- Eligibility: requester k is eligible when req_valid[k]=1 and req_flush[k]=0.
- Grant: combinational. If count<MAX_OUT and unit_ready_out=1, grant the first eligible requester found scanning k = rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Exactly one req_ready bit is set, only for the granted requester.
  - unit_valid_in = any grant; unit_payload = granted slice (0 when there is no grant).
- Issue (grant and unit_ready_out in the same cycle): push {owner=k, drop=0} to the owner FIFO; rr_ptr <= (k+1) mod NUM_REQ. rr_ptr does not change without a grant.
- Count is checked against the registered value. A pop in the same cycle does not free a slot for that cycle's issue, so there is no combinational path from rsp_ready to req_ready.
- Result routing: when unit_valid_out=1 and the FIFO is non-empty, inspect the head.
  - Head drop=0 and req_flush[owner]=0: rsp_valid[owner]=1, rsp_payload=unit_result, unit_ready_in=rsp_ready[owner].
  - Head drop=1, or req_flush[owner]=1 this cycle: rsp_valid all 0, unit_ready_in=1 (discard).
  - Pop on unit_valid_out && unit_ready_in.
  - Zero added latency; a result returns in the same cycle the unit presents it.
- Flush: req_flush[k]=1 sets drop on every valid FIFO entry whose owner=k. This includes an entry pushed in the same cycle, so a same-cycle issue cannot occur because k is ineligible.
  - Flush never affects other owners' entries, rr_ptr or count.
  - Flushed entries still occupy slots until the unit emits and they are popped.
- Push and pop in the same cycle: count unchanged; both pointers advance (wrap mod MAX_OUT).
- unit_valid_out=1 with an empty FIFO is a protocol error: unit_ready_in=1 (drain), no rsp_valid. Covered by an assertion in the bench.
- Backpressure: while the head owner holds rsp_ready=0, unit_ready_in=0. The unit stalls, and issue continues only until count=MAX_OUT.
- No ordering between requesters beyond FIFO order. Per-requester results are in issue order.
- Reset asserted mid-operation: FIFO contents are lost immediately. The shared unit is reset by the same reset_n, so no stale result appears.

Test Plan:
- Reset, then req_valid=2'b11 held, unit_ready_out=1, unit returns each result 1 cycle after issue, rsp_ready=2'b11 -> grants alternate 0,1,0,1; each rsp_valid pulses only for the owner with the matching result (e.g. 0x3F800000 -> int 1 to req0).
- MAX_OUT=2, rsp_ready=0 for both requesters, continuous requests -> exactly 2 issues, then req_ready=0 until the first pop; count never exceeds 2.
- Issue req0 then req1, assert req_flush[0] while req0's op is in flight -> req0's result is discarded with unit_ready_in=1 and rsp_valid[0]=0; req1's result is delivered normally.
- req_flush[1] in the same cycle that req1 is the only valid requester -> no grant, req_ready=0, rr_ptr unchanged.
- Head owner req1 holds rsp_ready=0 for 5 cycles while unit_valid_out=1 -> unit_ready_in=0 for 5 cycles; result delivered in cycle 6 unchanged.
- Assert reset_n=0 asynchronously mid-stream with 2 ops in flight -> all outputs 0 immediately; after release, the first grant goes to req0 (rr_ptr=0).
